// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential double-dabble BCD converter.
package bcd_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   localparam int               BCD_DIGIT_W       = 4;
   localparam logic [3:0]       BCD_ADJ_THRESHOLD = 4'd5;
   localparam logic [3:0]       BCD_ADJ_ADD       = 4'd3;

endpackage

// File: rtl/bcd_digit_adj.sv
// One BCD digit pre-shift correction: add 3 when the digit is 5 or more,
// so the following left shift carries correctly into the next digit.
module bcd_digit_adj
   import bcd_pkg::*;
(
   input  logic [BCD_DIGIT_W-1:0] digit,
   output logic [BCD_DIGIT_W-1:0] adj
);

   // add-3 correction
   always_comb begin
      if (digit >= BCD_ADJ_THRESHOLD) begin
         adj = digit + BCD_ADJ_ADD;
      end else begin
         adj = digit;
      end
   end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Iterative shift-and-add-3 binary-to-BCD converter with valid/ready handshakes.
// Optional leading-zero blank flags are built when BCD_LEADING_ZERO_BLANK_EN is defined.
module bin_to_bcd_seq
   import bcd_pkg::*;
#(
   parameter int BIN_WIDTH = 8,
   parameter int DIGITS    = 3
) (
   input  logic                          i_Clk,
   input  logic                          i_Rst_L,
   input  logic                          i_Valid,
   output logic                          o_Ready,
   input  logic [BIN_WIDTH-1:0]          i_Binary_Num,
   output logic                          o_Valid,
   input  logic                          i_Ready,
   output logic [BCD_DIGIT_W*DIGITS-1:0] o_BCD,
   output logic                          o_Overflow,
   output logic [DIGITS-1:0]             o_Blank
);

   localparam int              BCD_W    = BCD_DIGIT_W * DIGITS;
   localparam int              CNT_W    = $clog2(BIN_WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BIN_WIDTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t               state_r;
   logic [BIN_WIDTH-1:0] bin_r;
   logic [BCD_W-1:0]     bcd_r;
   logic                 ovf_r;
   logic [CNT_W-1:0]     cnt_r;
   logic                 ready_r;
   logic                 valid_r;

   logic [BCD_W-1:0]     adj_s;
   logic [BCD_W-1:0]     bcd_shift_s;
   logic [BIN_WIDTH-1:0] bin_shift_s;
   logic                 carry_s;

   genvar g;
   generate
      for (g = 0; g < DIGITS; g++) begin : g_adj
         bcd_digit_adj u_adj (
            .digit (bcd_r[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .adj   (adj_s[g*BCD_DIGIT_W +: BCD_DIGIT_W])
         );
      end
   endgenerate

   // one double-dabble step; the bit leaving the top digit is a carry past 10^DIGITS
   always_comb begin
      bcd_shift_s = {adj_s[BCD_W-2:0], bin_r[BIN_WIDTH-1]};
      bin_shift_s = {bin_r[BIN_WIDTH-2:0], 1'b0};
      carry_s     = adj_s[BCD_W-1];
   end

`ifdef BCD_LEADING_ZERO_BLANK_EN
   logic [DIGITS-1:0] blank_r;
   logic [DIGITS-1:0] blank_next_s;
   logic              zero_run_s;

   // digit i blanks when it and every higher digit are zero; digit 0 never blanks
   always_comb begin
      blank_next_s = {DIGITS{1'b0}};
      zero_run_s   = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         zero_run_s      = zero_run_s & (bcd_shift_s[i*BCD_DIGIT_W +: BCD_DIGIT_W] == 4'd0);
         blank_next_s[i] = zero_run_s;
      end
   end

   assign o_Blank = blank_r;
`else
   assign o_Blank = {DIGITS{1'b0}};
`endif

   // control FSM and datapath registers
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         state_r <= ST_IDLE;
         bin_r   <= {BIN_WIDTH{1'b0}};
         bcd_r   <= {BCD_W{1'b0}};
         ovf_r   <= 1'b0;
         cnt_r   <= {CNT_W{1'b0}};
         ready_r <= 1'b1;
         valid_r <= 1'b0;
`ifdef BCD_LEADING_ZERO_BLANK_EN
         blank_r <= {DIGITS{1'b0}};
`endif
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (i_Valid) begin
                  bin_r   <= i_Binary_Num;
                  bcd_r   <= {BCD_W{1'b0}};
                  ovf_r   <= 1'b0;
                  cnt_r   <= CNT_LOAD;
                  ready_r <= 1'b0;
                  state_r <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               bcd_r <= bcd_shift_s;
               bin_r <= bin_shift_s;
               cnt_r <= cnt_r - CNT_ONE;
               if (carry_s) begin
                  ovf_r <= 1'b1;
               end
               if (cnt_r == CNT_ONE) begin
                  valid_r <= 1'b1;
                  state_r <= ST_DONE;
`ifdef BCD_LEADING_ZERO_BLANK_EN
                  blank_r <= blank_next_s;
`endif
               end
            end
            ST_DONE: begin
               // result stays frozen until the display side takes it
               if (i_Ready) begin
                  valid_r <= 1'b0;
                  ready_r <= 1'b1;
                  state_r <= ST_IDLE;
`ifdef BCD_LEADING_ZERO_BLANK_EN
                  blank_r <= {DIGITS{1'b0}};
`endif
               end
            end
            default: begin
               valid_r <= 1'b0;
               ready_r <= 1'b1;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_Ready    = ready_r;
   assign o_Valid    = valid_r;
   assign o_BCD      = bcd_r;
   assign o_Overflow = ovf_r;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: 3-digit and 2-digit instances against a decimal arithmetic model.
module tb_bin_to_bcd_seq;

   logic        clk;
   logic        rst_n;

   logic        valid1, rdy_in1;
   logic [7:0]  num1;
   logic        ready1, ovalid1, ovf1;
   logic [11:0] bcd1;
   logic [2:0]  blank1;

   logic        valid2, rdy_in2;
   logic [7:0]  num2;
   logic        ready2, ovalid2, ovf2;
   logic [7:0]  bcd2;
   logic [1:0]  blank2;

   int total = 0;
   int bad   = 0;

   bin_to_bcd_seq #(.BIN_WIDTH(8), .DIGITS(3)) dut (
      .i_Clk(clk), .i_Rst_L(rst_n), .i_Valid(valid1), .o_Ready(ready1),
      .i_Binary_Num(num1), .o_Valid(ovalid1), .i_Ready(rdy_in1),
      .o_BCD(bcd1), .o_Overflow(ovf1), .o_Blank(blank1)
   );

   bin_to_bcd_seq #(.BIN_WIDTH(8), .DIGITS(2)) dut2 (
      .i_Clk(clk), .i_Rst_L(rst_n), .i_Valid(valid2), .o_Ready(ready2),
      .i_Binary_Num(num2), .o_Valid(ovalid2), .i_Ready(rdy_in2),
      .o_BCD(bcd2), .o_Overflow(ovf2), .o_Blank(blank2)
   );

   initial clk = 1'b0;
   always #20 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int pow10(input int d);
      int p;
      p = 1;
      for (int i = 0; i < d; i++) p = p * 10;
      return p;
   endfunction

   function automatic logic [31:0] exp_bcd(input int v, input int d);
      logic [31:0] r;
      int m;
      r = 32'd0;
      m = v;
      for (int i = 0; i < d; i++) begin
         r[4*i +: 4] = 4'(m % 10);
         m = m / 10;
      end
      return r;
   endfunction

   function automatic logic [31:0] exp_blank(input int v, input int d);
      logic [31:0] r;
      r = 32'd0;
`ifdef BCD_LEADING_ZERO_BLANK_EN
      for (int i = 1; i < d; i++) r[i] = ((v % pow10(d)) < pow10(i));
`endif
      return r;
   endfunction

   function automatic logic [31:0] obs_bcd(input int which);
      return (which == 0) ? {20'd0, bcd1} : {24'd0, bcd2};
   endfunction

   function automatic logic [31:0] obs_blank(input int which);
      return (which == 0) ? {29'd0, blank1} : {30'd0, blank2};
   endfunction

   // Accept v on one instance, check latency and result, optionally hand it off.
   task automatic run_conv(input int which, input int v, input bit ack);
      int d;
      int n;
      d = (which == 0) ? 3 : 2;
      n = 0;
      while (((which == 0) ? ready1 : ready2) !== 1'b1 && n < 30) begin
         @(negedge clk);
         n++;
      end
      chk("ready_before_accept", {31'd0, (which == 0) ? ready1 : ready2}, 32'd1);
      if (which == 0) begin valid1 = 1'b1; num1 = 8'(v); end
      else            begin valid2 = 1'b1; num2 = 8'(v); end
      @(posedge clk);
      #1;
      if (which == 0) begin valid1 = 1'b0; num1 = 8'($urandom); end
      else            begin valid2 = 1'b0; num2 = 8'($urandom); end
      n = 0;
      while (n < 20) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (((which == 0) ? ovalid1 : ovalid2) === 1'b1) break;
      end
      chk($sformatf("latency_%0d", v), n, 32'd8);
      chk($sformatf("bcd_%0d_d%0d", v, d), obs_bcd(which), exp_bcd(v, d));
      chk($sformatf("ovf_%0d_d%0d", v, d), {31'd0, (which == 0) ? ovf1 : ovf2},
          {31'd0, v >= pow10(d)});
      chk($sformatf("blank_%0d_d%0d", v, d), obs_blank(which), exp_blank(v, d));
      chk("ready_low_in_done", {31'd0, (which == 0) ? ready1 : ready2}, 32'd0);
      if (ack) begin
         if (which == 0) rdy_in1 = 1'b1; else rdy_in2 = 1'b1;
         @(negedge clk);
         if (which == 0) rdy_in1 = 1'b0; else rdy_in2 = 1'b0;
         chk("valid_after_ack", {31'd0, (which == 0) ? ovalid1 : ovalid2}, 32'd0);
         chk("ready_after_ack", {31'd0, (which == 0) ? ready1 : ready2}, 32'd1);
         chk("bcd_kept_in_idle", obs_bcd(which), exp_bcd(v, d));
      end
   endtask

   initial begin
      int v;
      rst_n  = 1'b0;
      valid1 = 1'b0; rdy_in1 = 1'b0; num1 = 8'd0;
      valid2 = 1'b0; rdy_in2 = 1'b0; num2 = 8'd0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_ready", {31'd0, ready1}, 32'd1);
      chk("rst_valid", {31'd0, ovalid1}, 32'd0);
      chk("rst_bcd", obs_bcd(0), 32'd0);
      chk("rst_ovf", {31'd0, ovf1}, 32'd0);
      chk("rst_blank", obs_blank(0), 32'd0);
      chk("rst_ready2", {31'd0, ready2}, 32'd1);

      run_conv(0, 255, 1'b1);
      run_conv(0, 30, 1'b1);
      run_conv(0, 0, 1'b1);
      run_conv(0, 100, 1'b1);
      run_conv(0, 9, 1'b1);
      for (int k = 0; k < 12; k++) begin
         v = int'($urandom_range(255, 0));
         run_conv(0, v, 1'b1);
      end

      // backpressure: result must survive ignored i_Valid pulses
      run_conv(0, 123, 1'b0);
      for (int k = 0; k < 5; k++) begin
         valid1 = 1'b1;
         num1   = 8'd99;
         @(negedge clk);
         chk("bp_bcd", obs_bcd(0), exp_bcd(123, 3));
         chk("bp_ready", {31'd0, ready1}, 32'd0);
         chk("bp_valid", {31'd0, ovalid1}, 32'd1);
      end
      valid1  = 1'b0;
      rdy_in1 = 1'b1;
      @(negedge clk);
      rdy_in1 = 1'b0;
      chk("bp_release_ready", {31'd0, ready1}, 32'd1);
      chk("bp_release_valid", {31'd0, ovalid1}, 32'd0);
      @(negedge clk);
      chk("bp_no_new_conv", {31'd0, ready1}, 32'd1);
      chk("bp_bcd_kept", obs_bcd(0), exp_bcd(123, 3));

      // asynchronous reset in the middle of a conversion
      valid1 = 1'b1;
      num1   = 8'd200;
      @(posedge clk);
      #1 valid1 = 1'b0;
      repeat (4) @(posedge clk);
      #10;
      chk("mid_busy", {31'd0, ready1}, 32'd0);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_ready", {31'd0, ready1}, 32'd1);
      chk("mid_rst_valid", {31'd0, ovalid1}, 32'd0);
      chk("mid_rst_bcd", obs_bcd(0), 32'd0);
      chk("mid_rst_ovf", {31'd0, ovf1}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_conv(0, 7, 1'b1);

      // two-digit instance: overflow keeps the value mod 100
      run_conv(1, 150, 1'b1);
      run_conv(1, 99, 1'b1);
      run_conv(1, 100, 1'b1);
      for (int k = 0; k < 8; k++) begin
         v = int'($urandom_range(255, 0));
         run_conv(1, v, 1'b1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
- Iterative shift-and-add-3 (double-dabble) binary-to-BCD converter.
- Sits between the operand adder and the per-digit 7-segment encoders. Converts the sum into decimal digits; each digit drives one display.
- Valid/ready handshake on input and output. Result is held until the downstream stage accepts it.

Parameters:
- BIN_WIDTH, 8: width of the binary input.
- DIGITS, 3: number of BCD digits produced. Output width is 4*DIGITS.

Ports:
- i_Clk  input  1  system clock (25 MHz).
- i_Rst_L  input  1  reset, asynchronous, active-low.
- i_Valid  input  1  input value present.
- o_Ready  output  1  converter idle and able to accept.
- i_Binary_Num  input  BIN_WIDTH  unsigned value to convert.
- o_Valid  output  1  result available.
- i_Ready  input  1  downstream accepts result.
- o_BCD  output  4*DIGITS  packed digits; digit 0 is in bits [3:0].
- o_Overflow  output  1  input is >= 10^DIGITS; o_BCD then holds the value mod 10^DIGITS.
- o_Blank  output  DIGITS  per-digit leading-zero blank flags (see Optional Feature).

Behaviour:
- Clocking and reset:
  - One clock domain. All state changes on the rising edge of i_Clk.
  - i_Rst_L low clears immediately, regardless of clock: state IDLE, o_Ready=1, o_Valid=0, o_BCD=0, o_Overflow=0, o_Blank=0, shift count=0.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - o_Ready=1.
  - On an edge with i_Valid=1: capture i_Binary_Num into the binary shift register, clear the BCD register and the overflow flag, load count=BIN_WIDTH, go to SHIFT.
- SHIFT (o_Ready=0, o_Valid=0). Each cycle, in a single edge:
  - Every BCD digit >= 5 gets +3.
  - Shift {BCD, binary} left one bit.
  - If the bit leaving the top digit is 1, set the sticky overflow flag.
  - Decrement count.
  - When count reaches 0, go to DONE.
- DONE:
  - o_Valid=1. o_BCD, o_Overflow and o_Blank are held stable.
  - Edge with i_Ready=1 goes to IDLE: o_Valid=0 and o_Ready=1 from the next cycle.
  - o_BCD keeps its last value in IDLE; it is not cleared.
- Latency: accept on edge E0 → o_Valid high after edge E0+BIN_WIDTH.
- Throughput: one conversion per BIN_WIDTH+2 cycles, with no back-to-back bypass.
- Input timing: i_Binary_Num is sampled only on the accept edge. Later changes have no effect.
- i_Valid outside IDLE: ignored, not queued.
- Reset asserted mid-SHIFT or in DONE: conversion is discarded and the block returns to IDLE.
- Input 0: o_BCD=0, o_Overflow=0.
- Elaboration check: if DIGITS*4 < BIN_WIDTH+1 is undersized, it is legal; the overflow flag covers it.

Optional Feature:
- Macro: BCD_LEADING_ZERO_BLANK_EN.
- Defined: in DONE, o_Blank[i]=1 when digit i and all higher digits are zero, for i >= 1. o_Blank[0] is always 0, so "0" still displays. The display stage drives all segments off for blanked digits.
- Undefined: o_Blank is tied to 0 and no blank logic is synthesised.

Decomposition:
- Shared package bcd_pkg:
  - state enum typedef (IDLE/SHIFT/DONE);
  - BCD_DIGIT_W=4;
  - BCD_ADJ_THRESHOLD=5;
  - BCD_ADJ_ADD=3.
- Sub-module bcd_digit_adj: combinational 4-bit add-3-if->=5 cell, instantiated DIGITS times via generate.

Test Plan:
- Reset release → o_Ready=1, o_Valid=0, o_BCD=12'h000, o_Overflow=0.
- i_Binary_Num=8'd255 with i_Valid pulse → o_Valid exactly 8 cycles after accept, o_BCD=12'h255, o_Overflow=0.
- i_Binary_Num=8'd30 with macro defined → o_BCD=12'h030, o_Blank=3'b100. Then 8'd0 → o_BCD=12'h000, o_Blank=3'b110.
- Backpressure: hold i_Ready=0 for 5 cycles in DONE while pulsing i_Valid with 8'd99 → o_BCD stays at prior result, o_Ready=0, no new conversion. Release i_Ready → IDLE next cycle.
- Assert i_Rst_L low 4 cycles into converting 8'd200, between clock edges → outputs clear immediately. Next conversion of 8'd7 → 12'h007.
- DIGITS=2 instance, i_Binary_Num=8'd150 → o_BCD=8'h50, o_Overflow=1. Then 8'd99 → 8'h99, o_Overflow=0.
